cond_chain_arbiter: RTL and testbench
=====================================

Name: cond_chain_arbiter

Overview:
- Sequential arbiter that shares one resource between NREQ requesters.
- Winner selection mirrors a preprocessor if/elsif/else chain: first matching condition wins, lower index first.
- Sits in the simple-test suite as a synthesizable controller exercising FSMs, counters and a macro-selected arbitration policy.
- Grants are held until the owner releases, or until a hold timeout forces release.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum cycles a grant may be held before a forced release (>=2).
- GAP, 1, idle cycles inserted after every release before the next arbitration (0..7).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request vector; bit i high = requester i wants the resource.
- release  input  1  owner-independent early release strobe, sampled in BUSY only.
- grant  output  NREQ  one-hot grant, registered; all zero when no owner.
- grant_valid  output  1  high while any grant bit is high.
- grant_id  output  $clog2(NREQ)  index of current owner; holds last owner when grant_valid is low.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout=0, hold_cnt=0, gap_cnt=0, mask=0, rr_ptr=0.
- FSM states: IDLE, BUSY, COOL.
- IDLE:
  - Winner is picked from req & ~mask.
  - If no eligible requester: stay in IDLE and clear mask.
  - Otherwise: at the next edge, grant=onehot(winner), grant_id=winner, grant_valid=1, hold_cnt=0, state=BUSY.
  - Latency: req rising to grant high is 1 cycle.
- BUSY:
  - hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - Release condition: req[grant_id]==0 or release==1.
  - If the release condition holds: at the next edge grant=0, grant_valid=0, and mask is cleared.
  - Else if hold_cnt==MAX_HOLD-1: forced release. grant=0, timeout=1 for one cycle, and mask=onehot(grant_id) so the same requester cannot win the very next arbitration.
  - If release and timeout coincide, the normal release takes priority and timeout stays 0.
  - After release: next state is COOL if GAP>0, else IDLE.
- COOL:
  - gap_cnt counts 0..GAP-1 with grant=0, then state goes to IDLE.
  - Requests arriving in COOL are not lost; they are evaluated in IDLE.
- Mask: cleared after any IDLE arbitration that grants an unmasked requester.
  - If the masked requester is the only one requesting, it waits one IDLE cycle (mask clears), then wins.
- Simultaneous events: a req change in the same cycle as the grant edge has no effect until the next cycle. A release strobe in IDLE or COOL is ignored.
- Mid-operation reset: all outputs drop to reset values immediately (asynchronous). No timeout pulse is produced.
- grant is always one-hot or zero; grant_valid == |grant.

Optional Feature:
- Macro: COND_CHAIN_ROUND_ROBIN_EN.
- Without the macro: fixed priority. The lowest index wins, like the first true branch of an elsif chain; rr_ptr is unused and stays 0.
- With the macro: round-robin.
  - The search starts at rr_ptr and wraps modulo NREQ.
  - On each grant, rr_ptr = (winner+1) mod NREQ; wrap-around from NREQ-1 goes to 0.
  - The mask logic still applies on top of the rotation.

Test Plan:
- Reset: assert rst mid-BUSY with grant=4'b0100 -> grant=0, grant_valid=0, grant_id=0, timeout=0 asynchronously; after rst drops with req=0, outputs stay at reset values.
- Fixed priority: req=4'b1010 in IDLE -> next cycle grant=4'b0010, grant_id=1. Drop req[1] -> grant=0 next cycle, 1 COOL cycle, then grant=4'b1000.
- Timeout: req=4'b0001 held high, MAX_HOLD=8 -> grant held 8 cycles, then timeout=1 for one cycle, grant=0. After the COOL cycle and one masked IDLE cycle, grant=4'b0001 again.
- Masked rival: after a timeout of requester 0, with req=4'b0011 -> requester 1 wins (grant=4'b0010), not requester 0.
- Release vs timeout tie: release=1 on the last hold cycle -> grant=0, timeout stays 0, mask stays 0.
- Round-robin (macro defined): req=4'b1111 held, each owner releases after 1 cycle via release strobe -> grant_id sequence 0,1,2,3,0, wrapping from 3 to 0.

Source files
------------

// File: rtl/cond_chain_arbiter.sv
// Sequential NREQ-way arbiter (IDLE/BUSY/COOL) with hold timeout and post-release gap.
// Define COND_CHAIN_ROUND_ROBIN_EN for round-robin selection; fixed lowest-index priority otherwise.
module cond_chain_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     release_strobe,
    output logic [NREQ-1:0]          grant,
    output logic                     grant_valid,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     timeout
);

    localparam int IDW = $clog2(NREQ);
    localparam int HW  = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [2:0]      gap_cnt;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  winner;
    logic            found;

`ifdef COND_CHAIN_ROUND_ROBIN_EN
    logic [IDW-1:0]  rr_ptr;

    // Scan starts at rr_ptr and wraps; first eligible requester in scan order wins.
    always_comb begin
        int unsigned    pos;
        logic [IDW-1:0] idx;
        eligible = req & ~mask;
        winner   = '0;
        found    = 1'b0;
        pos      = 0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(rr_ptr) + k;
            if (pos >= NREQ)
                pos = pos - NREQ;
            idx = IDW'(pos);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
`else
    always_comb begin
        eligible = req & ~mask;
        winner   = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && eligible[IDW'(i)]) begin
                found  = 1'b1;
                winner = IDW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            mask        <= '0;
`ifdef COND_CHAIN_ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    mask <= '0;
                    if (found) begin
                        grant       <= NREQ'(1) << winner;
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        hold_cnt    <= '0;
                        state       <= BUSY;
`ifdef COND_CHAIN_ROUND_ROBIN_EN
                        rr_ptr      <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (hold_cnt != HW'(MAX_HOLD - 1))
                        hold_cnt <= hold_cnt + 1'b1;
                    // Owner/strobe release outranks the timeout on the same edge.
                    if (!req[grant_id] || release_strobe) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        mask        <= '0;
                        gap_cnt     <= '0;
                        state       <= (GAP > 0) ? COOL : IDLE;
                    end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        mask        <= grant;
                        gap_cnt     <= '0;
                        state       <= (GAP > 0) ? COOL : IDLE;
                    end
                end
                COOL: begin
                    if (gap_cnt == 3'(GAP - 1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cond_chain_arbiter.sv
// Self-checking bench for cond_chain_arbiter: vector table, directed corner sequences,
// then random traffic against a requester-level reference model.
module tb_cond_chain_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 8;
    localparam int GAP      = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            rel;
    logic [NREQ-1:0] grant;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic            timeout;

    int vectors    = 0;
    int miscompares = 0;

    cond_chain_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .release_strobe (rel),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .grant_id       (grant_id),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rel;
        logic [3:0] grant;
        logic       valid;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[10];

    // Reference model: who owns the resource, how long, who is barred, where the scan starts.
    int m_owner, m_held, m_cool, m_banned, m_start, m_id;
    bit m_to;

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_cool = 0; m_banned = -1; m_start = 0; m_id = 0; m_to = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input bit rl);
        int w;
        m_to = 0;
        if (m_owner >= 0) begin
            m_held++;
            if (!r[m_owner] || rl) begin
                m_owner = -1; m_banned = -1; m_cool = GAP;
            end else if (m_held == MAX_HOLD) begin
                m_to = 1; m_banned = m_owner; m_owner = -1; m_cool = GAP;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_start + k) % NREQ;
                if (w < 0 && r[i] && i != m_banned) w = i;
            end
            m_banned = -1;
            if (w >= 0) begin
                m_owner = w; m_held = 0; m_id = w;
`ifdef COND_CHAIN_ROUND_ROBIN_EN
                m_start = (w + 1) % NREQ;
`endif
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic rl);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; rel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int exp_ids[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[2] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};
        tbl[3] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[4] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
        tbl[5] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[6] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
        tbl[7] = '{4'b1000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0};
        tbl[9] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};

        rst = 1'b1; req = '0; rel = 1'b0;
        @(posedge clk); #1;
        chk("reset_grant", grant, 0);
        chk("reset_valid", grant_valid, 0);
        chk("reset_id", grant_id, 0);
        chk("reset_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) begin
            apply(tbl[n].req, tbl[n].rel);
            chk($sformatf("tbl%0d_grant", n), grant, tbl[n].grant);
            chk($sformatf("tbl%0d_valid", n), grant_valid, tbl[n].valid);
            chk($sformatf("tbl%0d_id", n), grant_id, tbl[n].id);
            chk($sformatf("tbl%0d_timeout", n), timeout, tbl[n].to);
        end

        // Asynchronous reset while requester 2 owns the resource.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_valid", grant_valid, 0);
        chk("async_rst_id", grant_id, 0);
        chk("async_rst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        for (int n = 0; n < 3; n++) begin
            apply(4'b0000, 1'b0);
            chk("post_rst_grant", grant, 0);
            chk("post_rst_id", grant_id, 0);
        end

        // Timeout of requester 0, masked idle cycle, then re-grant.
        for (int n = 0; n < MAX_HOLD; n++) begin
            apply(4'b0001, 1'b0);
            chk("hold_grant", grant, 4'b0001);
            chk("hold_timeout", timeout, 0);
        end
        apply(4'b0001, 1'b0);
        chk("to_grant", grant, 0);
        chk("to_valid", grant_valid, 0);
        chk("to_pulse", timeout, 1);
        apply(4'b0001, 1'b0);
        chk("to_cool_grant", grant, 0);
        chk("to_pulse_end", timeout, 0);
        apply(4'b0001, 1'b0);
        chk("masked_idle_grant", grant, 0);
        apply(4'b0001, 1'b0);
        chk("regrant_grant", grant, 4'b0001);
        chk("regrant_id", grant_id, 0);

        // Second timeout, then a rival should beat the masked requester.
        for (int n = 0; n < MAX_HOLD - 1; n++) apply(4'b0001, 1'b0);
        apply(4'b0001, 1'b0);
        chk("to2_pulse", timeout, 1);
        apply(4'b0011, 1'b0);
        chk("rival_cool_grant", grant, 0);
        apply(4'b0011, 1'b0);
        chk("rival_grant", grant, 4'b0010);
        chk("rival_id", grant_id, 1);

        // Release strobe on the last hold cycle: no timeout, no mask.
        for (int n = 0; n < MAX_HOLD - 1; n++) apply(4'b0011, 1'b0);
        chk("tie_pre_grant", grant, 4'b0010);
        apply(4'b0011, 1'b1);
        chk("tie_grant", grant, 0);
        chk("tie_timeout", timeout, 0);
        apply(4'b0010, 1'b0);
        apply(4'b0010, 1'b0);
        chk("tie_nomask_grant", grant, 4'b0010);
        chk("tie_nomask_id", grant_id, 1);
        apply(4'b0000, 1'b0);
        chk("drop_grant", grant, 0);

        // All request, strobe release every grant: rotation (or fixed winner 0).
`ifdef COND_CHAIN_ROUND_ROBIN_EN
        exp_ids = '{0, 1, 2, 3, 0};
`else
        exp_ids = '{0, 0, 0, 0, 0};
`endif
        do_reset();
        for (int n = 0; n < 13; n++) begin
            apply(4'b1111, 1'b1);
            if (n % 3 == 0) begin
                chk($sformatf("rot%0d_valid", n / 3), grant_valid, 1);
                chk($sformatf("rot%0d_id", n / 3), grant_id, exp_ids[n / 3]);
            end
        end

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            rel = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            model_step(req, rel);
            #1;
            chk("rnd_grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("rnd_valid", grant_valid, (m_owner >= 0) ? 1 : 0);
            chk("rnd_id", grant_id, m_id);
            chk("rnd_timeout", timeout, m_to);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
